// File: rtl/sc_countdown_scheduler_pkg.sv
// Shared state encoding, window-table defaults and window decode helpers
// for the countdown scheduler.
package sc_countdown_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_WIN   = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  localparam logic [1:0] WINIDX_NONE   = 2'd3;
  localparam logic [7:0] DEF_TICK_MAX  = 8'd127;
  localparam logic [7:0] DEF_WIN0_OPEN = 8'd12;
  localparam logic [7:0] DEF_WIN0_CLOSE = 8'd16;
  localparam logic [7:0] DEF_WIN1_OPEN = 8'd48;
  localparam logic [7:0] DEF_WIN1_CLOSE = 8'd52;
  localparam logic [7:0] DEF_WIN2_OPEN = 8'd95;
  localparam logic [7:0] DEF_WIN2_CLOSE = 8'd99;

  // Windows are half-open [open, close); ordering makes them disjoint.
  function automatic logic [1:0] win_lookup(
    input logic [7:0] t,
    input logic [7:0] o0, input logic [7:0] c0,
    input logic [7:0] o1, input logic [7:0] c1,
    input logic [7:0] o2, input logic [7:0] c2
  );
    if (t >= o0 && t < c0) return 2'd0;
    if (t >= o1 && t < c1) return 2'd1;
    if (t >= o2 && t < c2) return 2'd2;
    return WINIDX_NONE;
  endfunction

  function automatic logic is_close(
    input logic [7:0] t,
    input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2
  );
    return (t == c0) || (t == c1) || (t == c2);
  endfunction

endpackage

// File: rtl/sc_countdown_scheduler_sync.sv
// Start-button synchroniser: 2-FF sync plus falling-edge press detector.
module sc_button_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press,
  output logic released
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the released level so leaving reset never fakes a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= btn_n;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign press    = prev_q & ~sync_q;
  assign released = sync_q;

endmodule

// File: rtl/sc_countdown_scheduler.sv
// Countdown sequencer: prescaled tick counter, start/restart handling and
// three scheduled countdown windows with run/done status.
module sc_countdown_scheduler
  import sc_countdown_scheduler_pkg::*;
#(
  parameter int unsigned PRESCALE_MAX = 5000000,
  parameter logic [7:0]  TICK_MAX     = DEF_TICK_MAX,
  parameter logic [7:0]  WIN0_OPEN    = DEF_WIN0_OPEN,
  parameter logic [7:0]  WIN0_CLOSE   = DEF_WIN0_CLOSE,
  parameter logic [7:0]  WIN1_OPEN    = DEF_WIN1_OPEN,
  parameter logic [7:0]  WIN1_CLOSE   = DEF_WIN1_CLOSE,
  parameter logic [7:0]  WIN2_OPEN    = DEF_WIN2_OPEN,
  parameter logic [7:0]  WIN2_CLOSE   = DEF_WIN2_CLOSE
) (
  input  logic       SC_COUNTDOWNSCHED_CLOCK_50,
  input  logic       SC_COUNTDOWNSCHED_RESET_InLow,
  input  logic       SC_COUNTDOWNSCHED_startButton_InLow,
  input  logic       SC_COUNTDOWNSCHED_ENABLE_InHigh,
  output logic [7:0] SC_COUNTDOWNSCHED_TICK_Out,
  output logic       SC_COUNTDOWNSCHED_TICKSTROBE_Out,
  output logic       SC_COUNTDOWNSCHED_ACTIVE_Out,
  output logic [1:0] SC_COUNTDOWNSCHED_WINIDX_Out,
  output logic       SC_COUNTDOWNSCHED_WINDONE_Out,
  output logic       SC_COUNTDOWNSCHED_BUSY_Out,
  output logic       SC_COUNTDOWNSCHED_DONE_Out
);

  localparam int unsigned PW = (PRESCALE_MAX > 2) ? $clog2(PRESCALE_MAX) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_MAX - 1);

  if (!(PRESCALE_MAX >= 2 && WIN0_OPEN > 8'd0 && WIN0_OPEN < WIN0_CLOSE &&
        WIN0_CLOSE <= WIN1_OPEN && WIN1_OPEN < WIN1_CLOSE &&
        WIN1_CLOSE <= WIN2_OPEN && WIN2_OPEN < WIN2_CLOSE &&
        WIN2_CLOSE < TICK_MAX)) begin : g_bad_params
    $error("sc_countdown_scheduler: illegal prescale or window table");
  end

  logic press;
  logic released;

  sc_button_sync u_sync (
    .clk      (SC_COUNTDOWNSCHED_CLOCK_50),
    .rst_n    (SC_COUNTDOWNSCHED_RESET_InLow),
    .btn_n    (SC_COUNTDOWNSCHED_startButton_InLow),
    .press    (press),
    .released (released)
  );

  sched_state_t  state_q, state_d;
  logic [7:0]    tick_q, tick_d, tick_inc;
  logic [PW-1:0] presc_q, presc_d;
  logic          strobe_q, strobe_d;
  logic          windone_q, windone_d;

  always_ff @(posedge SC_COUNTDOWNSCHED_CLOCK_50 or negedge SC_COUNTDOWNSCHED_RESET_InLow) begin
    if (!SC_COUNTDOWNSCHED_RESET_InLow) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      presc_q   <= '0;
      strobe_q  <= 1'b0;
      windone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      presc_q   <= presc_d;
      strobe_q  <= strobe_d;
      windone_q <= windone_d;
    end
  end

  // Next state is decided on tick+1 so state and tick land on the same edge.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    presc_d   = presc_q;
    strobe_d  = 1'b0;
    windone_d = 1'b0;
    tick_inc  = tick_q + 8'd1;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (press) begin
          state_d = ST_ARMED;
          tick_d  = '0;
          presc_d = '0;
        end
      end
      ST_ARMED: begin
        tick_d  = '0;
        presc_d = '0;
        if (released) state_d = ST_RUN;
      end
      ST_RUN, ST_WIN: begin
        if (press) begin
          state_d = ST_ARMED;
          tick_d  = '0;
          presc_d = '0;
        end else if (SC_COUNTDOWNSCHED_ENABLE_InHigh) begin
          if (presc_q == PRESC_LAST) begin
            presc_d   = '0;
            tick_d    = tick_inc;
            strobe_d  = 1'b1;
            windone_d = is_close(tick_inc, WIN0_CLOSE, WIN1_CLOSE, WIN2_CLOSE);
            if (tick_inc == TICK_MAX)
              state_d = ST_DONE;
            else if (win_lookup(tick_inc, WIN0_OPEN, WIN0_CLOSE, WIN1_OPEN, WIN1_CLOSE,
                                WIN2_OPEN, WIN2_CLOSE) != WINIDX_NONE)
              state_d = ST_WIN;
            else
              state_d = ST_RUN;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign SC_COUNTDOWNSCHED_TICK_Out       = tick_q;
  assign SC_COUNTDOWNSCHED_TICKSTROBE_Out = strobe_q;
  assign SC_COUNTDOWNSCHED_ACTIVE_Out     = (state_q == ST_WIN);
  assign SC_COUNTDOWNSCHED_WINIDX_Out     = (state_q == ST_WIN)
      ? win_lookup(tick_q, WIN0_OPEN, WIN0_CLOSE, WIN1_OPEN, WIN1_CLOSE, WIN2_OPEN, WIN2_CLOSE)
      : WINIDX_NONE;
  assign SC_COUNTDOWNSCHED_WINDONE_Out    = windone_q;
  assign SC_COUNTDOWNSCHED_BUSY_Out       = (state_q == ST_RUN) || (state_q == ST_WIN);
  assign SC_COUNTDOWNSCHED_DONE_Out       = (state_q == ST_DONE);

endmodule

// File: tb/tb_sc_countdown_scheduler.sv
// Self-checking bench for sc_countdown_scheduler with a cycle-level behavioural model.
module tb_sc_countdown_scheduler;

  localparam int P = 4;
  localparam int TMAX = 127;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       en;
  logic [7:0] tick;
  logic       strobe, active, windone, busy, done;
  logic [1:0] widx;

  int n_checks = 0;
  int n_errors = 0;

  // model state: mode, tick, prescale phase, button samples (newest first)
  int m_mode, m_tick, m_ph;
  bit m_strobe, m_wd;
  bit hist [3];

  int w_open  [3] = '{12, 48, 95};
  int w_close [3] = '{16, 52, 99};

  always #5 clk = ~clk;

  sc_countdown_scheduler #(.PRESCALE_MAX(P)) dut (
    .SC_COUNTDOWNSCHED_CLOCK_50          (clk),
    .SC_COUNTDOWNSCHED_RESET_InLow       (rst_n),
    .SC_COUNTDOWNSCHED_startButton_InLow (btn_n),
    .SC_COUNTDOWNSCHED_ENABLE_InHigh     (en),
    .SC_COUNTDOWNSCHED_TICK_Out          (tick),
    .SC_COUNTDOWNSCHED_TICKSTROBE_Out    (strobe),
    .SC_COUNTDOWNSCHED_ACTIVE_Out        (active),
    .SC_COUNTDOWNSCHED_WINIDX_Out        (widx),
    .SC_COUNTDOWNSCHED_WINDONE_Out       (windone),
    .SC_COUNTDOWNSCHED_BUSY_Out          (busy),
    .SC_COUNTDOWNSCHED_DONE_Out          (done)
  );

  function automatic int win_of(input int t);
    for (int k = 0; k < 3; k++)
      if (t >= w_open[k] && t < w_close[k]) return k;
    return 3;
  endfunction

  function automatic bit is_close_tick(input int t);
    for (int k = 0; k < 3; k++)
      if (t == w_close[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_tick = 0; m_ph = 0; m_strobe = 0; m_wd = 0;
    for (int i = 0; i < 3; i++) hist[i] = 1'b1;
  endtask

  // The button is seen two edges late; a press is the first low sample after a high one.
  task automatic model_edge();
    bit lvl, pr;
    lvl = hist[1];
    pr  = hist[2] && !hist[1];
    m_strobe = 0;
    m_wd = 0;
    case (m_mode)
      M_IDLE, M_DONE: if (pr) begin m_mode = M_ARMED; m_tick = 0; m_ph = 0; end
      M_ARMED: if (lvl) m_mode = M_RUN;
      default: begin
        if (pr) begin
          m_mode = M_ARMED; m_tick = 0; m_ph = 0;
        end else if (en) begin
          if (m_ph == P - 1) begin
            m_ph = 0;
            m_tick = m_tick + 1;
            m_strobe = 1;
            m_wd = is_close_tick(m_tick);
            if (m_tick == TMAX) m_mode = M_DONE;
          end else begin
            m_ph = m_ph + 1;
          end
        end
      end
    endcase
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = btn_n;
  endtask

  task automatic check_all(input string tag);
    logic [14:0] obs, expv;
    logic [7:0]  et;
    logic [1:0]  ew;
    int          w;
    et = m_tick[7:0];
    w  = win_of(m_tick);
    ew = w[1:0];
    obs  = {tick, strobe, active, widx, windone, busy, done};
    expv = {et, m_strobe, (w != 3), ew, m_wd, (m_mode == M_RUN), (m_mode == M_DONE)};
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h (tick,strobe,active,widx,windone,busy,done)",
             tag, obs, expv);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    check_all(tag);
  endtask

  task automatic run_until(input int t, input int p, input int bound, input string tag);
    int n;
    n = 0;
    while (!(m_tick == t && m_ph == p) && n < bound) begin
      cyc(tag);
      n++;
    end
    chk({tag, "_reached"}, {24'd0, tick}, t);
  endtask

  task automatic press_release(input int hold);
    btn_n = 1'b0;
    repeat (hold) cyc("press");
    btn_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lo_cnt;
    rst_n = 1'b0; btn_n = 1'b1; en = 1'b1;
    model_reset();
    repeat (3) cyc("reset");
    chk("reset_winidx", {30'd0, widx}, 3);
    chk("reset_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    repeat (3) cyc("idle");

    // start: 2-cycle press, then release
    press_release(2);
    n = 0;
    while (m_mode != M_RUN && n < 10) begin cyc("arm"); n++; end
    chk("busy_after_release", {31'd0, busy}, 1);
    repeat (3) cyc("first_tick");
    chk("tick0_before_4clk", {24'd0, tick}, 0);
    cyc("first_tick");
    chk("tick1_after_4clk", {24'd0, tick}, 1);
    chk("first_strobe", {31'd0, strobe}, 1);

    // pause inside window 0
    run_until(13, 0, 200, "to13");
    en = 1'b0;
    repeat (20) cyc("pause");
    chk("pause_tick", {24'd0, tick}, 13);
    chk("pause_active", {31'd0, active}, 1);
    en = 1'b1;
    repeat (3) cyc("resume");
    chk("resume_hold", {24'd0, tick}, 13);
    cyc("resume");
    chk("resume_tick14", {24'd0, tick}, 14);

    run_until(16, 0, 200, "to16");
    chk("win0_done", {31'd0, windone}, 1);
    chk("win0_inactive", {31'd0, active}, 0);

    // press lands on the same edge as the 50->51 strobe
    run_until(50, 1, 400, "to50");
    chk("win1_idx", {30'd0, widx}, 1);
    btn_n = 1'b0;
    repeat (3) cyc("abort");
    chk("abort_tick", {24'd0, tick}, 0);
    chk("abort_active", {31'd0, active}, 0);
    chk("abort_windone", {31'd0, windone}, 0);
    chk("abort_strobe", {31'd0, strobe}, 0);
    cyc("abort");
    btn_n = 1'b1;
    n = 0;
    while (m_mode != M_RUN && n < 10) begin cyc("rearm"); n++; end

    // full run to the end
    run_until(48, 0, 400, "to48");
    chk("win1_open", {30'd0, widx}, 1);
    run_until(52, 0, 100, "to52");
    chk("win1_done", {31'd0, windone}, 1);
    run_until(95, 0, 400, "to95");
    chk("win2_open", {30'd0, widx}, 2);
    run_until(99, 0, 100, "to99");
    chk("win2_done", {31'd0, windone}, 1);
    run_until(TMAX, 0, 200, "to127");
    chk("end_done", {31'd0, done}, 1);
    chk("end_busy", {31'd0, busy}, 0);
    repeat (20) cyc("hold_end");
    chk("end_hold_tick", {24'd0, tick}, TMAX);
    chk("end_no_strobe", {31'd0, strobe}, 0);

    // randomized enables and presses
    press_release(2);
    lo_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if (lo_cnt > 0) begin
        lo_cnt--;
        btn_n = (lo_cnt == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        lo_cnt = $urandom_range(1, 4);
        btn_n = 1'b0;
      end
      cyc("random");
    end
    btn_n = 1'b1; en = 1'b1;
    repeat (6) cyc("settle");

    // asynchronous reset mid-run
    press_release(2);
    run_until(20, 2, 300, "to20");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset_winidx", {30'd0, widx}, 3);
    repeat (3) cyc("in_reset");
    rst_n = 1'b1;
    repeat (4) cyc("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
